apb_master_bridge: RTL and testbench

//  APB3 requester: turns a simple valid/ready command stream (core LSU / debug

---
 rtl/apb_master_bridge.sv | 124 ++++++++++++
 tb/tb_apb_master_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3 requester bridge: valid/ready command in, one SETUP/ACCESS transfer out,
// PRDATA/PSLVERR returned on a valid/ready response channel; ACCESS bounded by a timeout.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero-width counter is illegal, so the disabled case keeps one bit.
    localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  psel_q;
    logic                  penable_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q   <= cmd_addr;
                        pwrite_q  <= cmd_write;
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so a completion in the last allowed cycle wins.
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (TO_EN && cnt_q == CNT_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: latency, wait states, errors, timeout,
// response back-pressure and reset during ACCESS.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_write = 1'b0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the SETUP cycle. Holds PREADY low for 'waits' ACCESS cycles
    // (PSLVERR=werr meanwhile), then raises it with rd/err. Returns the number
    // of cycles seen with PSEL&PENABLE before rsp_valid rose.
    task automatic access(input int waits, input logic [DW-1:0] rd, input logic err,
                          input logic werr, input logic [AW-1:0] addr, output int ncyc);
        ncyc = 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) break;
            if (PSEL && PENABLE) ncyc++;
            chk("paddr_stable", PADDR, addr);
            PREADY  = (ncyc > waits);
            PRDATA  = PREADY ? rd : 32'h0BAD_0BAD;
            PSLVERR = PREADY ? err : werr;
            tick();
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        chk("rsp_valid_arrived", rsp_valid, 1'b1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", rsp_valid, 1'b0);
        chk("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] held;

        // Reset state
        tick();
        tick();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        PRESET = 1'b0;
        tick();

        // 1. zero-wait write: SETUP, ACCESS, then response
        PREADY = 1'b1;
        issue(32'h1000_0004, 1'b1, 32'hDEAD_BEEF);
        chk("t1_setup_psel", PSEL, 1'b1);
        chk("t1_setup_penable", PENABLE, 1'b0);
        chk("t1_setup_cmd_ready", cmd_ready, 1'b0);
        chk("t1_paddr", PADDR, 32'h1000_0004);
        chk("t1_pwrite", PWRITE, 1'b1);
        chk("t1_pwdata", PWDATA, 32'hDEAD_BEEF);
        PRDATA = 32'h5555_AAAA;
        tick();
        chk("t1_access_psel", PSEL, 1'b1);
        chk("t1_access_penable", PENABLE, 1'b1);
        chk("t1_access_no_rsp", rsp_valid, 1'b0);
        tick();
        PREADY = 1'b0;
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk("t1_psel_low", PSEL, 1'b0);
        chk("t1_penable_low", PENABLE, 1'b0);
        consume();
        chk("t1_idle_paddr_held", PADDR, 32'h1000_0004);

        // 2. read with three wait states
        issue(32'h0000_0020, 1'b0, 32'hFFFF_FFFF);
        chk("t2_pwdata_zero", PWDATA, 32'h0);
        chk("t2_pwrite", PWRITE, 1'b0);
        access(3, 32'h1234_5678, 1'b0, 1'b0, 32'h20, n);
        chk("t2_access_cycles", n, 4);
        chk("t2_rdata", rsp_rdata, 32'h1234_5678);
        chk("t2_err", rsp_err, 1'b0);
        consume();

        // 3a. read with PSLVERR on completion
        issue(32'h0000_0030, 1'b0, 32'h0);
        access(0, 32'hCAFE_0001, 1'b1, 1'b0, 32'h30, n);
        chk("t3a_access_cycles", n, 1);
        chk("t3a_err", rsp_err, 1'b1);
        chk("t3a_rdata", rsp_rdata, 32'hCAFE_0001);
        consume();

        // 3b. PSLVERR only while PREADY low must be ignored
        issue(32'h0000_0034, 1'b0, 32'h0);
        access(2, 32'hCAFE_0002, 1'b0, 1'b1, 32'h34, n);
        chk("t3b_access_cycles", n, 3);
        chk("t3b_err", rsp_err, 1'b0);
        chk("t3b_rdata", rsp_rdata, 32'hCAFE_0002);
        consume();

        // 4a. PREADY stuck low: abort after exactly 8 ACCESS cycles
        issue(32'h0000_0040, 1'b0, 32'h0);
        access(100, 32'h0, 1'b0, 1'b0, 32'h40, n);
        chk("t4a_access_cycles", n, 8);
        chk("t4a_err", rsp_err, 1'b1);
        chk("t4a_rdata", rsp_rdata, 32'h0);
        chk("t4a_psel", PSEL, 1'b0);
        chk("t4a_penable", PENABLE, 1'b0);
        consume();

        // 4b. PREADY in the 8th cycle completes normally
        issue(32'h0000_0044, 1'b0, 32'h0);
        access(7, 32'h0808_0808, 1'b0, 1'b0, 32'h44, n);
        chk("t4b_access_cycles", n, 8);
        chk("t4b_err", rsp_err, 1'b0);
        chk("t4b_rdata", rsp_rdata, 32'h0808_0808);
        consume();

        // 5. response back-pressure with a pending second command
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0050;
        cmd_write = 1'b0;
        cmd_wdata = 32'h0;
        tick();
        cmd_addr  = 32'h0000_0060;
        cmd_write = 1'b1;
        cmd_wdata = 32'h6666_6666;
        access(0, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h50, n);
        held = rsp_rdata;
        chk("t5_rdata", held, 32'hA5A5_5A5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", rsp_valid, 1'b1);
            chk("t5_hold_rdata", rsp_rdata, 32'hA5A5_5A5A);
            chk("t5_hold_err", rsp_err, 1'b0);
            chk("t5_cmd_ready_low", cmd_ready, 1'b0);
            chk("t5_no_psel", PSEL, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_hs_valid", rsp_valid, 1'b0);
        chk("t5_hs_cmd_ready", cmd_ready, 1'b1);
        chk("t5_hs_no_psel", PSEL, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("t5_second_psel", PSEL, 1'b1);
        chk("t5_second_paddr", PADDR, 32'h60);
        chk("t5_second_pwdata", PWDATA, 32'h6666_6666);
        access(0, 32'h0, 1'b0, 1'b0, 32'h60, n);
        chk("t5_second_rdata", rsp_rdata, 32'h0);
        consume();

        // 6. reset during ACCESS drops the transfer silently
        issue(32'h0000_0070, 1'b0, 32'h0);
        tick();
        chk("t6_in_access", PENABLE, 1'b1);
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("t6_psel", PSEL, 1'b0);
        chk("t6_penable", PENABLE, 1'b0);
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        chk("t6_cmd_ready", cmd_ready, 1'b1);
        PREADY = 1'b1;
        PRDATA = 32'h7777_7777;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_rsp", rsp_valid, 1'b0);
            chk("t6_no_psel", PSEL, 1'b0);
        end
        PREADY = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
